// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state codes and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int LAST_TICK  = OVERSAMPLE - 1;

  // Bits needed to hold values 0..max_val, never less than min_bits.
  function automatic int cnt_width(input int max_val, input int min_bits);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return (w < min_bits) ? min_bits : w;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; the reset value is
// chosen per use so that an idle line does not look like activity after reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start detection, mid-bit data sampling,
// optional parity check and stop-bit check, with a one-clock rx_done strobe.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low (checked every clk)
// START  | counting to mid start bit to reject glitches
// DATA   | sampling DBIT data bits at mid-bit, LSB first
// PARITY | sampling the parity bit and computing the mismatch
// STOP   | waiting SB_TICK ticks, then sampling the stop bit
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int SW = cnt_width(SB_TICK - 1, 4);
  localparam int NW = cnt_width(DBIT - 1, 1);

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(LAST_TICK);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  uart_state_e     state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] shreg, shreg_next;
  logic            p_err, p_err_next;
  logic            frame_end;
  logic            rx_s;

  // Synchroniser resets high so the idle line is not mistaken for a start bit.
  uart_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shreg <= '0;
      p_err <= 1'b0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      shreg <= shreg_next;
      p_err <= p_err_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shreg_next = shreg;
    p_err_next = p_err;
    frame_end  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            // A start bit that is high again by mid-bit is treated as noise.
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            shreg_next = {rx_s, shreg[DBIT-1:1]};
            s_next     = '0;
            if (n == N_LAST) begin
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            p_err_next = (^shreg) ^ rx_s ^ ODD;
            state_next = STOP;
            s_next     = '0;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            state_next = IDLE;
            frame_end  = 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Word and both error flags are published together with the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_done <= frame_end;
      if (frame_end) begin
        rx_data    <= shreg;
        frame_err  <= ~rx_s;
        parity_err <= (PARITY_EN != 0) ? p_err : 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a default 8N1 receiver and an even-parity
// receiver, each fed its own serial line and checked against a frame-level model.
module tb_uart_rx_core;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_done, frame_err, parity_err, busy;
  logic       rx_done_p, frame_err_p, parity_err_p, busy_p;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  rec_t got_q[$], got_p_q[$], exp_q[$], exp_p_q[$];
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_rx_core u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_tick     (s_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_tick     (s_tick),
    .rx         (rx_p),
    .rx_data    (rx_data_p),
    .rx_done    (rx_done_p),
    .frame_err  (frame_err_p),
    .parity_err (parity_err_p),
    .busy       (busy_p)
  );

  // 16x baud tick: one clock high every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done)   got_q.push_back(rec_t'({rx_data, frame_err, parity_err}));
    if (rx_done_p) got_p_q.push_back(rec_t'({rx_data_p, frame_err_p, parity_err_p}));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v, input bit on_par, input int clks);
    if (on_par) rx_p = v;
    else rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // Drives one frame and records what the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input bit on_par, input logic pbit,
                            input logic stop_val);
    rec_t e;
    drive_bit(1'b0, on_par, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(d[i], on_par, BIT_CLK);
    if (on_par) drive_bit(pbit, on_par, BIT_CLK);
    if (stop_val) begin
      drive_bit(1'b1, on_par, BIT_CLK);
    end else begin
      drive_bit(1'b0, on_par, 48);
      drive_bit(1'b1, on_par, BIT_CLK);
    end
    e.data = d;
    e.ferr = ~stop_val;
    e.perr = on_par ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
    if (on_par) exp_p_q.push_back(e);
    else exp_q.push_back(e);
  endtask

  task automatic clear_queues();
    got_q.delete(); got_p_q.delete(); exp_q.delete(); exp_p_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({rx_data, rx_done, frame_err, parity_err, busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h done=%b ferr=%b perr=%b busy=%b expected all 0",
               rx_data, rx_done, frame_err, parity_err, busy);
    end
    checks++;
    if ({rx_data_p, rx_done_p, frame_err_p, parity_err_p, busy_p} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs_par: got data=%h done=%b ferr=%b perr=%b busy=%b expected all 0",
               rx_data_p, rx_done_p, frame_err_p, parity_err_p, busy_p);
    end
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b strobes=%0d expected 0 and 0", busy, got_q.size());
    end
  endtask

  task automatic test_single_frame();
    clear_queues();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL frame55_count: got %0d strobes expected 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0] || got_q[0].data !== 8'h55) begin
        fails++;
        $display("FAIL frame55_word: got %h/%b/%b expected %h/%b/%b", got_q[0].data, got_q[0].ferr,
                 got_q[0].perr, exp_q[0].data, exp_q[0].ferr, exp_q[0].perr);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL frame55_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_glitch();
    clear_queues();
    drive_bit(1'b0, 1'b0, 12);
    drive_bit(1'b1, 1'b0, 3 * BIT_CLK);
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_reject: got strobes=%0d busy=%b expected 0 and 0", got_q.size(), busy);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL glitch_next_frame: got strobes=%0d word=%h expected 1 and %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 8'h00, exp_q[0].data);
    end
  endtask

  task automatic test_frame_err();
    clear_queues();
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, BIT_CLK);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL ferr_count: got %0d strobes expected %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL ferr_word%0d: got %h/ferr=%b expected %h/ferr=%b", i, got_q[i].data,
                   got_q[i].ferr, exp_q[i].data, exp_q[i].ferr);
        end
      end
    end
  endtask

  task automatic test_parity();
    clear_queues();
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
    checks++;
    if (got_p_q.size() != 2 || got_q.size() != 0) begin
      fails++;
      $display("FAIL parity_count: got %0d/%0d strobes expected 2/0", got_p_q.size(), got_q.size());
    end else begin
      foreach (exp_p_q[i]) begin
        checks++;
        if (got_p_q[i] !== exp_p_q[i]) begin
          fails++;
          $display("FAIL parity_word%0d: got %h perr=%b ferr=%b expected %h perr=%b ferr=%b", i,
                   got_p_q[i].data, got_p_q[i].perr, got_p_q[i].ferr, exp_p_q[i].data,
                   exp_p_q[i].perr, exp_p_q[i].ferr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    clear_queues();
    d = 8'h99;
    drive_bit(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0, BIT_CLK);
    drive_bit(d[4], 1'b0, 30);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midframe_busy: got %b expected 1", busy);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_done, frame_err, parity_err, busy} !== 12'h000) begin
      fails++;
      $display("FAIL async_reset: got data=%h done=%b ferr=%b perr=%b busy=%b expected all 0",
               rx_data, rx_done, frame_err, parity_err, busy);
    end
    @(negedge clk);
    drive_bit(1'b1, 1'b0, 3);
    reset_n = 1'b1;
    drive_bit(1'b1, 1'b0, 4 * BIT_CLK);
    checks++;
    if (got_q.size() != 0) begin
      fails++;
      $display("FAIL reset_discard: got %0d strobes expected 0", got_q.size());
    end
    exp_q.delete();
    send_frame(8'hC4, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL after_reset_frame: got strobes=%0d word=%h expected 1 and %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 8'h00, exp_q[0].data);
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d strobes expected 3", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL b2b_word%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].data,
                   got_q[i].ferr, got_q[i].perr, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
        end
      end
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int k = 0; k < 16; k++) begin
      bit on_par;
      on_par = (k % 3 == 2);
      send_frame(8'($urandom_range(0, 255)), on_par, 1'($urandom_range(0, 1)), 1'b1);
      drive_bit(1'b1, on_par, $urandom_range(0, 100));
    end
    checks++;
    if (got_q.size() != exp_q.size() || got_p_q.size() != exp_p_q.size()) begin
      fails++;
      $display("FAIL random_count: got %0d/%0d strobes expected %0d/%0d", got_q.size(),
               got_p_q.size(), exp_q.size(), exp_p_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random_word%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].data,
                   got_q[i].ferr, got_q[i].perr, exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
        end
      end
      foreach (exp_p_q[i]) begin
        checks++;
        if (got_p_q[i] !== exp_p_q[i]) begin
          fails++;
          $display("FAIL random_par_word%0d: got %h/%b/%b expected %h/%b/%b", i, got_p_q[i].data,
                   got_p_q[i].ferr, got_p_q[i].perr, exp_p_q[i].data, exp_p_q[i].ferr,
                   exp_p_q[i].perr);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_err();
    test_parity();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
